// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI command sequencer.
//   - seq_state_e     : sequencer FSM state encoding
//   - DEF_*           : default controller register map and byte gap
//   - BUS_IDLE_*      : master-port values driven whenever no access is active
//   - gap_width()     : width of the WAIT-state down-counter for a given gap
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_MODE = 3'd1,
        ST_WR_CLK  = 3'd2,
        ST_READY   = 3'd3,
        ST_WR_DATA = 3'd4,
        ST_WAIT    = 3'd5
    } seq_state_e;

    localparam logic [31:0] DEF_MODE_ADDR   = 32'h0000_0000;
    localparam logic [31:0] DEF_CLKDIV_ADDR = 32'h0000_000C;
    localparam logic [31:0] DEF_TXDATA_ADDR = 32'h0000_0010;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0014;
    localparam int          DEF_BYTE_GAP    = 200;

    localparam logic        BUS_IDLE_CEN   = 1'b1;
    localparam logic        BUS_IDLE_WEN   = 1'b1;
    localparam logic [31:0] BUS_IDLE_ADDR  = 32'h0000_0000;
    localparam logic [31:0] BUS_IDLE_WDATA = 32'h0000_0000;

    // Idle cycles inserted between a "busy" status read result and the next poll.
    localparam int POLL_RETRY_GAP = 2;

    // At least 2 bits so the same counter can also hold POLL_RETRY_GAP.
    function automatic int gap_width(input int gap);
        int w;
        w = $clog2(gap + 1);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/spi_seq_bus_if.sv
// One-cycle access generator for the SPI controller master port.
// A request presented in cycle N becomes a single bus access in cycle N+1
// (MST_CEn low); in cycle N+2 the port is back at its idle values, done is
// high and rdata carries the read data returned by the controller.
//
// Ports:
//   CLK, RESETn          clock, asynchronous active-low reset
//   req, we, addr, wdata access request (we=1 write, we=0 read)
//   done                 high the cycle after an access
//   rdata                MST_RDATA, meaningful while done is high
//   MST_CEn, MST_WEn     registered active-low chip/write enables
//   MST_ADDR, MST_WDATA  registered address / write data (0 when idle)
//   MST_RDATA            read data from the controller
module spi_seq_bus_if
    import spi_seq_pkg::*;
(
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        MST_CEn,
    output logic        MST_WEn,
    output logic [31:0] MST_ADDR,
    output logic [31:0] MST_WDATA,
    input  logic [31:0] MST_RDATA
);

    logic        cen_q, cen_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;

    always_comb begin
        cen_d   = BUS_IDLE_CEN;
        wen_d   = BUS_IDLE_WEN;
        addr_d  = BUS_IDLE_ADDR;
        wdata_d = BUS_IDLE_WDATA;
        // A request during an active access cannot be honoured without
        // producing back-to-back accesses, so it is masked here.
        if (req && cen_q) begin
            cen_d   = 1'b0;
            wen_d   = ~we;
            addr_d  = addr;
            wdata_d = we ? wdata : BUS_IDLE_WDATA;
        end
        done_d = ~cen_q;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cen_q   <= BUS_IDLE_CEN;
            wen_q   <= BUS_IDLE_WEN;
            addr_q  <= BUS_IDLE_ADDR;
            wdata_q <= BUS_IDLE_WDATA;
            done_q  <= 1'b0;
        end else begin
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign MST_CEn   = cen_q;
    assign MST_WEn   = wen_q;
    assign MST_ADDR  = addr_q;
    assign MST_WDATA = wdata_q;
    assign done      = done_q;
    assign rdata     = MST_RDATA;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: writes MODE and CLKDIV into the SPI controller on
// CFG_START, then turns each byte of a valid/ready stream into one TXDATA
// write, pacing writes so the controller can keep up.
//
// Build option: SPI_SEQ_POLL_EN -- pace by polling STATUS.busy instead of
// waiting a fixed BYTE_GAP cycles after each TXDATA write.
//
// Ports:
//   CLK, RESETn              clock, asynchronous active-low reset
//   CFG_START                pulse: (re)run configuration (IDLE/READY only)
//   CFG_MODE, CFG_CLKDIV     configuration values, sampled with CFG_START
//   CFG_DONE                 configuration written; cleared by CFG_START
//   TX_VALID, TX_DATA        byte stream input
//   TX_READY                 byte accepted when TX_VALID && TX_READY
//   BUSY                     sequencer is in a non-IDLE/READY state
//   MST_CEn .. MST_RDATA     SPI controller master port
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | unconfigured, waiting for CFG_START
// ST_WR_MODE | MODE write in flight, then one idle cycle
// ST_WR_CLK  | CLKDIV write in flight, then one idle cycle
// ST_READY   | configured, TX_READY high, waiting for a byte
// ST_WR_DATA | TXDATA write in flight
// ST_WAIT    | pacing: fixed gap countdown, or STATUS polling
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter logic [31:0] MODE_ADDR   = DEF_MODE_ADDR,
    parameter logic [31:0] CLKDIV_ADDR = DEF_CLKDIV_ADDR,
    parameter logic [31:0] TXDATA_ADDR = DEF_TXDATA_ADDR,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter int          BYTE_GAP    = DEF_BYTE_GAP
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        CFG_START,
    input  logic [9:0]  CFG_MODE,
    input  logic [15:0] CFG_CLKDIV,
    output logic        CFG_DONE,
    input  logic        TX_VALID,
    input  logic [7:0]  TX_DATA,
    output logic        TX_READY,
    output logic        BUSY,
    output logic        MST_CEn,
    output logic        MST_WEn,
    output logic [31:0] MST_ADDR,
    output logic [31:0] MST_WDATA,
    input  logic [31:0] MST_RDATA
);

    localparam int GAP_W = gap_width(BYTE_GAP);

    seq_state_e        state_q, state_d;
    logic [15:0]       clkdiv_q, clkdiv_d;
    logic              cfg_done_q, cfg_done_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              bus_req;
    logic              bus_we;
    logic [31:0]       bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_done;
    logic [31:0]       bus_rdata;

    spi_seq_bus_if u_bus_if (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .req       (bus_req),
        .we        (bus_we),
        .addr      (bus_addr),
        .wdata     (bus_wdata),
        .done      (bus_done),
        .rdata     (bus_rdata),
        .MST_CEn   (MST_CEn),
        .MST_WEn   (MST_WEn),
        .MST_ADDR  (MST_ADDR),
        .MST_WDATA (MST_WDATA),
        .MST_RDATA (MST_RDATA)
    );

    always_comb begin
        state_d    = state_q;
        clkdiv_d   = clkdiv_q;
        cfg_done_d = cfg_done_q;
        gap_d      = gap_q;
        bus_req    = 1'b0;
        bus_we     = 1'b1;
        bus_addr   = BUS_IDLE_ADDR;
        bus_wdata  = BUS_IDLE_WDATA;

        unique case (state_q)
            ST_IDLE, ST_READY: begin
                // The MODE value goes straight into the bus write-data
                // register this cycle, so only CLKDIV needs holding here.
                if (CFG_START) begin
                    clkdiv_d   = CFG_CLKDIV;
                    cfg_done_d = 1'b0;
                    bus_req    = 1'b1;
                    bus_addr   = MODE_ADDR;
                    bus_wdata  = {22'b0, CFG_MODE};
                    state_d    = ST_WR_MODE;
                end else if (tx_ready_q && TX_VALID) begin
                    // Issuing the request on the handshake edge gives a
                    // one-cycle handshake-to-access latency.
                    bus_req   = 1'b1;
                    bus_addr  = TXDATA_ADDR;
                    bus_wdata = {24'b0, TX_DATA};
                    state_d   = ST_WR_DATA;
                end
            end

            ST_WR_MODE: begin
                if (bus_done) begin
                    bus_req   = 1'b1;
                    bus_addr  = CLKDIV_ADDR;
                    bus_wdata = {16'b0, clkdiv_q};
                    state_d   = ST_WR_CLK;
                end
            end

            ST_WR_CLK: begin
                if (bus_done) begin
                    cfg_done_d = 1'b1;
                    state_d    = ST_READY;
                end
            end

            ST_WR_DATA: begin
                if (bus_done) begin
`ifdef SPI_SEQ_POLL_EN
                    bus_req  = 1'b1;
                    bus_we   = 1'b0;
                    bus_addr = STATUS_ADDR;
                    gap_d    = '0;
`else
                    gap_d    = GAP_W'(BYTE_GAP);
`endif
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
`ifdef SPI_SEQ_POLL_EN
                // gap_q == 0 and no done: the status read is still in flight.
                if (bus_done) begin
                    if (bus_rdata[0]) begin
                        gap_d = GAP_W'(POLL_RETRY_GAP);
                    end else begin
                        state_d = ST_READY;
                    end
                end else if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                    if (gap_q == GAP_W'(1)) begin
                        bus_req  = 1'b1;
                        bus_we   = 1'b0;
                        bus_addr = STATUS_ADDR;
                    end
                end
`else
                if (gap_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        tx_ready_d = (state_d == ST_READY);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_READY);
    end

`ifdef SPI_SEQ_POLL_EN
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus_rdata[31:1];
`else
    // Write-only bus in this build: read data and STATUS address are unused.
    logic unused_poll;
    assign unused_poll = ^{bus_rdata, STATUS_ADDR};
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= ST_IDLE;
            clkdiv_q   <= '0;
            cfg_done_q <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            clkdiv_q   <= clkdiv_d;
            cfg_done_q <= cfg_done_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            gap_q      <= gap_d;
        end
    end

    assign CFG_DONE = cfg_done_q;
    assign TX_READY = tx_ready_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer. Expected bus writes are queued
// by the stimulus tasks from the configuration/byte values they drive; a
// negedge monitor pops them against each observed access and checks the
// timing rules (idle cycle between accesses, handshake latency, byte gap).
module tb_spi_cmd_sequencer;

    localparam int          G      = 10;
    localparam logic [31:0] A_MODE = 32'h00;
    localparam logic [31:0] A_CLK  = 32'h0C;
    localparam logic [31:0] A_TX   = 32'h10;
    localparam logic [31:0] A_STAT = 32'h14;

    logic        CLK        = 1'b0;
    logic        RESETn     = 1'b0;
    logic        CFG_START  = 1'b0;
    logic [9:0]  CFG_MODE   = '0;
    logic [15:0] CFG_CLKDIV = '0;
    logic        CFG_DONE;
    logic        TX_VALID   = 1'b0;
    logic [7:0]  TX_DATA    = '0;
    logic        TX_READY;
    logic        BUSY;
    logic        MST_CEn;
    logic        MST_WEn;
    logic [31:0] MST_ADDR;
    logic [31:0] MST_WDATA;
    logic [31:0] MST_RDATA  = 32'hDEAD_BEEF;

    spi_cmd_sequencer #(.BYTE_GAP(G)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .CFG_START  (CFG_START),
        .CFG_MODE   (CFG_MODE),
        .CFG_CLKDIV (CFG_CLKDIV),
        .CFG_DONE   (CFG_DONE),
        .TX_VALID   (TX_VALID),
        .TX_DATA    (TX_DATA),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .MST_CEn    (MST_CEn),
        .MST_WEn    (MST_WEn),
        .MST_ADDR   (MST_ADDR),
        .MST_WDATA  (MST_WDATA),
        .MST_RDATA  (MST_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Reference model: ordered expected writes and handshake cycles.
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          hs_q[$];
    int          last_acc = -100;
    int          last_tx  = -100;
    bit          first_tx = 1'b1;
    logic [31:0] ea, ed;

`ifdef SPI_SEQ_POLL_EN
    int polls     = 0;
    int busy_left = 3;
    always @(posedge CLK) begin
        if (!MST_CEn && MST_WEn) begin
            MST_RDATA <= {31'b0, busy_left != 0};
            if (busy_left != 0) busy_left--;
        end
    end
`endif

    task automatic check_write();
        chk("acc_we", 32'(MST_WEn), 0);
        chk("acc_expected", 32'(exp_addr_q.size() != 0), 1);
        if (exp_addr_q.size() != 0) begin
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            chk("acc_addr", MST_ADDR, ea);
            chk("acc_data", MST_WDATA, ed);
            if (ea == A_TX) begin
                chk("hs_pending", 32'(hs_q.size() != 0), 1);
                if (hs_q.size() != 0) chk("hs_latency", cyc, hs_q.pop_front() + 1);
                if (!first_tx) begin
`ifdef SPI_SEQ_POLL_EN
                    chk("poll_count", polls, 4);
`else
                    chk("tx_spacing", 32'((cyc - last_tx) >= G + 2), 1);
`endif
                end
                first_tx = 1'b0;
                last_tx  = cyc;
`ifdef SPI_SEQ_POLL_EN
                polls     = 0;
                busy_left = 3;
`endif
            end
        end
    endtask

    always @(negedge CLK) begin
        if (RESETn && !MST_CEn) begin
            chk("acc_idle_gap", 32'((cyc - last_acc) >= 2), 1);
            last_acc = cyc;
`ifdef SPI_SEQ_POLL_EN
            if (MST_WEn) begin
                chk("poll_addr", MST_ADDR, A_STAT);
                polls++;
            end else begin
                check_write();
            end
`else
            check_write();
`endif
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!TX_READY && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_timeout", 32'(w < 400), 1);
    endtask

    // Offers one byte; returns at the negedge of its bus access.
    task automatic send_byte(input logic [7:0] b, input bit keep);
        int w = 0;
        TX_DATA  = b;
        TX_VALID = 1'b1;
        while (!TX_READY && w < 400) begin
            @(negedge CLK);
            w++;
        end
        chk("tx_timeout", 32'(w < 400), 1);
        if (TX_READY) begin
            chk("done_at_hs", 32'(CFG_DONE), 1);
            exp_addr_q.push_back(A_TX);
            exp_data_q.push_back({24'b0, b});
            hs_q.push_back(cyc);
            @(negedge CLK);
            chk("tx_ready_drop", 32'(TX_READY), 0);
        end
        if (!keep) TX_VALID = 1'b0;
    endtask

    task automatic do_cfg(input logic [9:0] m, input logic [15:0] d,
                          input bit with_byte, input logic [7:0] b);
        int w = 0;
        CFG_START  = 1'b1;
        CFG_MODE   = m;
        CFG_CLKDIV = d;
        if (with_byte) begin
            TX_VALID = 1'b1;
            TX_DATA  = b;
        end
        exp_addr_q.push_back(A_MODE);
        exp_data_q.push_back({22'b0, m});
        exp_addr_q.push_back(A_CLK);
        exp_data_q.push_back({16'b0, d});
        @(negedge CLK);
        CFG_START  = 1'b0;
        CFG_MODE   = 10'($urandom);
        CFG_CLKDIV = 16'($urandom);
        chk("cfg_done_clr", 32'(CFG_DONE), 0);
        chk("cfg_busy", 32'(BUSY), 1);
        chk("cfg_tx_ready_low", 32'(TX_READY), 0);
        while (!CFG_DONE && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk("cfg_timeout", 32'(w < 50), 1);
        chk("cfg_tx_ready", 32'(TX_READY), 1);
        chk("cfg_busy_clr", 32'(BUSY), 0);
        chk("cfg_writes_left", exp_addr_q.size(), 0);
        if (with_byte) send_byte(b, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_cen", 32'(MST_CEn), 1);
        chk("rst_wen", 32'(MST_WEn), 1);
        chk("rst_addr", MST_ADDR, 0);
        chk("rst_wdata", MST_WDATA, 0);
        chk("rst_cfg_done", 32'(CFG_DONE), 0);
        chk("rst_tx_ready", 32'(TX_READY), 0);
        chk("rst_busy", 32'(BUSY), 0);
        RESETn = 1'b1;

        // Bytes offered while unconfigured are held off.
        TX_VALID = 1'b1;
        TX_DATA  = 8'h77;
        repeat (5) begin
            @(negedge CLK);
            chk("idle_hold", 32'(TX_READY), 0);
        end
        TX_VALID = 1'b0;

        do_cfg(10'h0D3, 16'h0063, 1'b0, 8'h00);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0);

        // CFG_START and TX_VALID in the same READY cycle.
        wait_ready();
        do_cfg(10'($urandom), 16'($urandom), 1'b1, 8'h5A);

        // CFG_START while busy is ignored.
        wait_ready();
        send_byte(8'($urandom), 1'b0);
        repeat (3) @(negedge CLK);
        CFG_START = 1'b1;
        CFG_MODE  = 10'($urandom);
        @(negedge CLK);
        CFG_START = 1'b0;
        chk("ign_busy", 32'(BUSY), 1);
        chk("ign_cfg_done", 32'(CFG_DONE), 1);
        wait_ready();
        chk("ign_cfg_done_after", 32'(CFG_DONE), 1);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                TX_VALID = 1'b0;
                wait_ready();
                do_cfg(10'($urandom), 16'($urandom), ($urandom_range(0, 1) == 1), 8'($urandom));
            end else if ($urandom_range(0, 1) == 1) begin
                send_byte(8'($urandom), 1'b1);
            end else begin
                send_byte(8'($urandom), 1'b0);
                repeat ($urandom_range(0, 15)) @(negedge CLK);
            end
        end
        TX_VALID = 1'b0;

        // Reset during the TXDATA access.
        wait_ready();
        send_byte(8'hC3, 1'b0);
        chk("wr_data_active", 32'(MST_CEn), 0);
        #1 RESETn = 1'b0;
        #1;
        chk("arst_cen", 32'(MST_CEn), 1);
        chk("arst_wen", 32'(MST_WEn), 1);
        chk("arst_addr", MST_ADDR, 0);
        chk("arst_wdata", MST_WDATA, 0);
        chk("arst_cfg_done", 32'(CFG_DONE), 0);
        chk("arst_busy", 32'(BUSY), 0);
        @(negedge CLK);
        RESETn   = 1'b1;
        first_tx = 1'b1;
`ifdef SPI_SEQ_POLL_EN
        polls     = 0;
        busy_left = 3;
`endif
        repeat (G + 10) @(negedge CLK);
        chk("post_rst_tx_ready", 32'(TX_READY), 0);
        chk("post_rst_cfg_done", 32'(CFG_DONE), 0);
        chk("post_rst_busy", 32'(BUSY), 0);
        chk("post_rst_pending", exp_addr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (%0d/%0d passed)", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
Bus-master front end that drives the SPI controller's memory-mapped master port (MST_CEn/MST_WEn, active-low) so software/datapath logic need not sequence register writes by hand. On CFG_START it writes the MODE and CLKDIV registers. It then accepts bytes on a valid/ready stream and issues one TXDATA write per byte, pacing successive writes until the controller can take the next one. Sits directly upstream of the SPI controller top.

Parameters:
MODE_ADDR, 32'h00, byte address of controller MODE register
CLKDIV_ADDR, 32'h0C, byte address of clock-divider register
TXDATA_ADDR, 32'h10, byte address of TX data register
STATUS_ADDR, 32'h14, byte address of status register (bit0 = busy); used only with SPI_SEQ_POLL_EN
BYTE_GAP, 200, CLK cycles waited after each TXDATA write (fixed-gap mode); minimum 1

Ports:
CLK  in  1  system clock
RESETn  in  1  asynchronous active-low reset
CFG_START  in  1  one-cycle pulse: (re)run configuration
CFG_MODE  in  10  value written to MODE (zero-extended to 32)
CFG_CLKDIV  in  16  value written to CLKDIV (zero-extended)
CFG_DONE  out  1  high once configuration written; cleared by CFG_START
TX_VALID  in  1  byte available
TX_DATA  in  8  byte to transmit
TX_READY  out  1  sequencer accepts byte this cycle
BUSY  out  1  high in any state other than IDLE/READY
MST_CEn  out  1  bus chip enable, active-low
MST_WEn  out  1  bus write enable, active-low (high = read)
MST_ADDR  out  32  bus address
MST_WDATA  out  32  bus write data
MST_RDATA  in  32  bus read data, valid the cycle after a read access

Behaviour:
- Reset: MST_CEn=1, MST_WEn=1, MST_ADDR=0, MST_WDATA=0, CFG_DONE=0, TX_READY=0, BUSY=0, state IDLE, gap counter 0. All outputs registered.
- Bus access = exactly one CLK cycle with MST_CEn=0; next cycle MST_CEn=1, MST_WEn=1, ADDR/WDATA return to 0. Never two back-to-back accesses (≥1 idle cycle between).
- CFG_MODE/CFG_CLKDIV sampled on the CFG_START cycle into internal registers.
- States: IDLE -> (CFG_START) WR_MODE -> WR_CLK -> READY; READY -> (TX_VALID&&TX_READY) WR_DATA -> WAIT -> READY.
- WR_MODE: one write {22'b0,mode} to MODE_ADDR, then one idle cycle. WR_CLK: write {16'b0,clkdiv} to CLKDIV_ADDR, then one idle cycle; CFG_DONE rises entering READY.
- READY: TX_READY=1; handshake captures TX_DATA; TX_READY drops the next cycle. Latency handshake -> MST_CEn low = 1 cycle.
- WR_DATA: write {24'b0,byte} to TXDATA_ADDR.
- WAIT (fixed-gap): counter loads BYTE_GAP, decrements to 0, then READY. Next TXDATA access is never earlier than BYTE_GAP+2 cycles after the previous one.
- CFG_START in any state other than IDLE/READY is ignored. In READY, CFG_START has priority over TX_VALID: CFG_DONE clears, reconfigure, no byte accepted that cycle.
- TX_VALID in IDLE: TX_READY=0, byte held off (no data loss).
- Async reset mid-access: bus deasserts immediately; captured byte discarded.

Optional Feature:
SPI_SEQ_POLL_EN: when defined, WAIT replaces the gap counter with polling. Issue a read at STATUS_ADDR (MST_WEn=1), sample MST_RDATA[0] the following cycle; if 1, wait 2 idle cycles and re-poll; if 0, go to READY. Undefined: fixed BYTE_GAP wait, bus is write-only, MST_RDATA is unused.

Decomposition:
- Package spi_seq_pkg: state encoding constants, default register addresses, bus idle values.
- One sub-module, spi_seq_bus_if: one-cycle access generator (req/addr/wdata/we in; done/rdata out) shared by all states.

Test Plan:
- Reset: hold RESETn=0 -> MST_CEn=1, MST_WEn=1, CFG_DONE=0, TX_READY=0.
- CFG_START with MODE=10'h0D3, CLKDIV=16'h0063 -> write 0x000000D3 @0x00, idle cycle, write 0x00000063 @0x0C, CFG_DONE=1, TX_READY=1.
- Bytes 0xA5, 0x3C streamed with TX_VALID constantly high, BYTE_GAP=10 -> two writes @0x10 with data 0xA5, 0x3C, spaced ≥12 cycles; TX_READY low between them.
- CFG_START and TX_VALID in the same READY cycle -> reconfiguration runs first; byte accepted only after CFG_DONE is re-asserted.
- POLL_EN: status model returns busy=1 three times, then 0 -> 4 reads @0x14, then TX_READY=1.
- RESETn pulled low during the WR_DATA cycle -> MST_CEn=1 immediately; after release, state is IDLE and CFG_DONE=0.
